// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared types and frame constants for the UART receiver
// Rev 1.0  : initial release (optional parity via UART_RX_PARITY_EN)
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int   CLKS_PER_BIT_9600 = 5208;
  localparam int   DATA_BITS         = 8;
  localparam logic STOP_VAL          = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } rx_state_t;

  // Even parity: the parity bit equals the XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : two-flop synchronizer for the serial line, resets to idle (1)
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_async,
  output logic rx_sync
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      meta    <= rx_async;
      rx_sync <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver, mid-bit sampling; optional even parity when
//           UART_RX_PARITY_EN is defined
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_cpb_check
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 par_pulse;
`endif

  uart_rx_sync u_sync (
    .clk      (i_Clock),
    .rst_n    (i_Rst_n),
    .rx_async (i_Rx_Serial),
    .rx_sync  (rx_s)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Rx_Byte   <= '0;
      o_Rx_DV     <= 1'b0;
      o_Rx_Active <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      par_pulse   <= 1'b0;
`endif
    end else begin
      // Pulses are set only on the STOP->CLEANUP transition, so they last one cycle.
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pulse   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
          if (!rx_s) state <= START;
        end

        START: begin
          if (clk_cnt == MID_CNT) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state       <= DATA;
              o_Rx_Active <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            par_bad <= (rx_s != even_parity(shift));
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt   <= '0;
            o_Rx_Byte <= shift;
            state     <= CLEANUP;
            if (rx_s == STOP_VAL) begin
`ifdef UART_RX_PARITY_EN
              o_Rx_DV <= ~par_bad;
`else
              o_Rx_DV <= 1'b1;
`endif
            end else begin
              o_Frame_Err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            par_pulse <= par_bad;
`endif
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        CLEANUP: begin
          // A line held low (break) parks here instead of re-triggering START.
          if (rx_s) begin
            state       <= IDLE;
            o_Rx_Active <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = par_pulse;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : scoreboard bench for uart_rx with directed and random frames
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_byte;
  logic       dv;
  logic       active;
  logic       fe;
  logic       pe;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Rx_Serial  (rx),
    .o_Rx_Byte    (rx_byte),
    .o_Rx_DV      (dv),
    .o_Rx_Active  (active),
    .o_Frame_Err  (fe),
    .o_Parity_Err (pe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dv;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests   = 0;
  int   fails   = 0;
  int   dv_seen = 0;
  int   fe_seen = 0;
  logic prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Parity bit that makes the total count of ones even.
  function automatic logic par_of(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 1;
  endfunction

  // Expected outcome of one frame, straight from the frame rules.
  function automatic exp_t model(input logic [7:0] d, input logic stop, input logic par);
    exp_t e;
    e.data = d;
    e.fe   = (stop == 1'b0);
`ifdef UART_RX_PARITY_EN
    e.pe   = (par != par_of(d));
`else
    e.pe   = 1'b0;
    if (par === 1'bz) e.pe = 1'b0;
`endif
    e.dv   = stop && !e.pe;
    return e;
  endfunction

  // Drive a level for n bit-clocks; always starts and ends 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    exp_q.push_back(model(d, stop, par));
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold(par, CPB);
`endif
    hold(stop, CPB);
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses any result output.
  always @(negedge clk) begin
    if (prev_pulse) check("pulse_width", {29'd0, dv, fe, pe}, 32'd0);
    prev_pulse = dv | fe | pe;
    if (dv | fe | pe) begin
      if (dv) dv_seen++;
      if (fe) fe_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got dv=%0b fe=%0b pe=%0b byte=%0h, expected no pulse at %0t",
                 dv, fe, pe, rx_byte, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_flags", {29'd0, dv, fe, pe}, {29'd0, mon_e.dv, mon_e.fe, mon_e.pe});
        check("frame_byte", {24'd0, rx_byte}, {24'd0, mon_e.data});
        check("active_at_pulse", {31'd0, active}, 32'd1);
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;
    logic       glitch_rise;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {20'd0, dv, fe, pe, active, rx_byte}, 32'd0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    send_frame(8'h81, 1'b1, par_of(8'h81));
    hold(1'b1, 4);
    check("dv_count_81", dv_seen, 1);
    check("active_idle_81", {31'd0, active}, 32'd0);

    glitch_rise = 1'b0;
    rx = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (active) glitch_rise = 1'b1;
    end
    rx = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (active) glitch_rise = 1'b1;
    end
    check("glitch_active", {31'd0, glitch_rise}, 32'd0);
    hold(1'b1, 10);
    send_frame(8'h3C, 1'b1, par_of(8'h3C));
    hold(1'b1, 4);
    check("dv_count_3c", dv_seen, 2);

    send_frame(8'hA5, 1'b0, par_of(8'hA5));
    hold(1'b0, 12);
    check("break_holds_active", {31'd0, active}, 32'd1);
    hold(1'b0, 12);
    hold(1'b1, 5);
    check("break_released", {31'd0, active}, 32'd0);
    check("fe_count", fe_seen, 1);
    check("byte_held_a5", {24'd0, rx_byte}, 32'h0000_00A5);
    check("dv_count_break", dv_seen, 2);
    hold(1'b1, 10);

    send_frame(8'h00, 1'b1, par_of(8'h00));
    send_frame(8'hFF, 1'b1, par_of(8'hFF));
    send_frame(8'h55, 1'b1, par_of(8'h55));
    hold(1'b1, 4);
    check("dv_count_b2b", dv_seen, 5);

    d = 8'hC3;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(d[i], CPB);
    hold(d[4], 8);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_midframe", {20'd0, dv, fe, pe, active, rx_byte}, 32'd0);
    @(posedge clk); #1;
    hold(1'b1, 5);
    rst_n = 1'b1;
    hold(1'b1, 2 * CPB);
    check("dv_count_after_reset", dv_seen, 5);
    send_frame(8'h12, 1'b1, par_of(8'h12));
    hold(1'b1, 4);
    check("dv_count_12", dv_seen, 6);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 8);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 8);
    check("dv_count_parity", dv_seen, 7);
`endif

    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = par_of(d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, stop, par);
      if (stop) hold(1'b1, int'($urandom_range(0, 12)));
      else      hold(1'b1, int'($urandom_range(4, 20)));
    end
    hold(1'b1, 4);

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
